exec_datapath_slice: RTL and testbench
======================================

Name: exec_datapath_slice

Overview:
- Registered arithmetic/writeback slice of the execution unit.
- Operand-B select: register file read port 1 or instruction immediate.
- ALU: add/subtract with carry and zero flags.
- Writeback select (4:1): ALU result, immediate, memory load data, or register read port 0.
- One-cycle pipeline stage sitting between the register-file read ports and the register-file write port.

Parameters:
- DATA_BITS, default 8: width of all operands, results and the writeback bus.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- rd0_data  input  DATA_BITS  register read port 0; ALU operand A and writeback source 3
- rd1_data  input  DATA_BITS  register read port 1; ALU operand B when b_sel=0
- immediate  input  DATA_BITS  instruction immediate; operand B when b_sel=1; writeback source 1
- load_data  input  DATA_BITS  memory load data; writeback source 2
- b_sel  input  1  0 = rd1_data, 1 = immediate
- subtract  input  1  0 = A+B, 1 = A-B
- wr_sel  input  2  0 = ALU, 1 = immediate, 2 = load_data, 3 = rd0_data
- valid_in  input  1  operation valid this cycle
- wr_data  output  DATA_BITS  registered writeback value
- wr_valid  output  1  registered valid_in
- carry  output  1  registered ALU carry flag
- zero  output  1  registered ALU zero flag

Behaviour:
- Reset: on a rising clk edge with reset=1, wr_data=0, wr_valid=0, carry=0, zero=0. Reset overrides valid_in.
- Operand B: b_eff = b_sel ? immediate : rd1_data. Purely combinational.
- ALU: sum = rd0_data + (subtract ? ~b_eff : b_eff) + subtract, computed DATA_BITS+1 wide.
  - alu_res = sum[DATA_BITS-1:0]; alu_cout = sum[DATA_BITS]; alu_zero = (alu_res == 0).
  - Subtract carry means "no borrow": 5-3 gives carry=1; 3-5 gives carry=0.
  - Overflow wraps modulo 2^DATA_BITS. No saturation.
- Writeback mux: mux_out selected by wr_sel per the port list. All four codes are legal. There is no default/X case.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Each non-reset edge:
  - wr_valid <= valid_in.
  - If valid_in=1: wr_data <= mux_out.
  - If valid_in=0: wr_data holds its previous value.
- Flags:
  - Updated only on edges where valid_in=1 and wr_sel=0: carry <= alu_cout, zero <= alu_zero.
  - Otherwise (idle, immediate load, memory load, register move) flags hold. A later conditional jump tests the last ALU result.
- Operand changes while valid_in=0 have no effect on any output.
- Back-to-back valid operations are fully pipelined. Each edge captures an independent operation.
- Reset asserted mid-stream discards the in-flight operation. The first valid operation after reset deassertion behaves normally.

Optional Feature:
- Macro: EXEC_DATAPATH_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port overflow, 1 bit, registered.
  - Signed overflow = (rd0_data[MSB] == b_xor[MSB]) && (alu_res[MSB] != rd0_data[MSB]), where b_xor = subtract ? ~b_eff : b_eff.
  - Updated under the same condition as carry/zero. Reset value 0.
- When not defined: the port does not exist and the logic is not built. All other behaviour is identical.

Test Plan:
- Add: reset 2 cycles, then rd0=0x05, rd1=0x03, b_sel=0, subtract=0, wr_sel=0, valid_in=1 -> next cycle wr_data=0x08, wr_valid=1, carry=0, zero=0.
- Wrap and zero: rd0=0xFF, immediate=0x01, b_sel=1, subtract=0, wr_sel=0 -> wr_data=0x00, carry=1, zero=1.
- Subtract:
  - rd0=0x05, rd1=0x03, subtract=1 -> wr_data=0x02, carry=1, zero=0.
  - Then rd0=0x03, rd1=0x05 -> wr_data=0xFE, carry=0.
  - Then rd0=0x07, immediate=0x07, b_sel=1 -> wr_data=0x00, zero=1.
- Mux and flag hold: after the zero=1 result, issue wr_sel=1 imm=0x5A, then wr_sel=2 load=0xC3, then wr_sel=3 rd0=0x11 -> wr_data=0x5A, 0xC3, 0x11 on successive cycles; zero stays 1, carry unchanged.
- Valid gating and reset:
  - valid_in=0 with wr_sel=0 and changing operands -> wr_data, carry and zero hold; wr_valid=0.
  - Assert reset alongside valid_in=1 -> next cycle all outputs 0.
- Overflow (macro defined):
  - 0x7F+0x01 -> overflow=1, wr_data=0x80.
  - 0x80-0x01 -> overflow=1, wr_data=0x7F.
  - 0x05+0x03 -> overflow=0.

Source files
------------

// File: rtl/exec_datapath_slice.sv
// One-cycle registered ALU/writeback slice between the register-file read and write ports.
// Optional signed-overflow flag output enabled by EXEC_DATAPATH_OVERFLOW_FLAG_EN.
module exec_datapath_slice #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] rd0_data,
   input  logic [DATA_BITS-1:0] rd1_data,
   input  logic [DATA_BITS-1:0] immediate,
   input  logic [DATA_BITS-1:0] load_data,
   input  logic                 b_sel,
   input  logic                 subtract,
   input  logic [1:0]           wr_sel,
   input  logic                 valid_in,
   output logic [DATA_BITS-1:0] wr_data,
   output logic                 wr_valid,
   output logic                 carry,
`ifdef EXEC_DATAPATH_OVERFLOW_FLAG_EN
   output logic                 overflow,
`endif
   output logic                 zero
);

   localparam int unsigned SUM_BITS = DATA_BITS + 1;
   localparam int unsigned MSB      = DATA_BITS - 1;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_IMM  = 2'd1;
   localparam logic [1:0] WB_LOAD = 2'd2;
   localparam logic [1:0] WB_RD0  = 2'd3;

   logic [DATA_BITS-1:0] b_eff;
   logic [DATA_BITS-1:0] b_xor;
   logic [SUM_BITS-1:0]  sum;
   logic [DATA_BITS-1:0] alu_res;
   logic                 alu_cout;
   logic                 alu_zero;
   logic [DATA_BITS-1:0] mux_out;
   logic                 flag_upd;

   logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
   logic                 wr_valid_q, wr_valid_d;
   logic                 carry_q, carry_d;
   logic                 zero_q, zero_d;

   // Subtraction is A + ~B + 1, so the carry-out reads as "no borrow".
   always_comb begin
      b_eff    = b_sel ? immediate : rd1_data;
      b_xor    = subtract ? ~b_eff : b_eff;
      sum      = SUM_BITS'(rd0_data) + SUM_BITS'(b_xor) + SUM_BITS'(subtract);
      alu_res  = sum[DATA_BITS-1:0];
      alu_cout = sum[DATA_BITS];
      alu_zero = (alu_res == '0);
   end

   always_comb begin
      mux_out = alu_res;
      case (wr_sel)
         WB_ALU:  mux_out = alu_res;
         WB_IMM:  mux_out = immediate;
         WB_LOAD: mux_out = load_data;
         WB_RD0:  mux_out = rd0_data;
         default: mux_out = alu_res;
      endcase
   end

   // Flags track only the last ALU writeback so later branches see that result.
   assign flag_upd = valid_in && (wr_sel == WB_ALU);

   always_comb begin
      wr_valid_d = valid_in;
      wr_data_d  = wr_data_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      if (valid_in) begin
         wr_data_d = mux_out;
      end
      if (flag_upd) begin
         carry_d = alu_cout;
         zero_d  = alu_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_data_q  <= '0;
         wr_valid_q <= 1'b0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         carry_q    <= carry_d;
         zero_q     <= zero_d;
      end
   end

   assign wr_data  = wr_data_q;
   assign wr_valid = wr_valid_q;
   assign carry    = carry_q;
   assign zero     = zero_q;

`ifdef EXEC_DATAPATH_OVERFLOW_FLAG_EN
   logic alu_ovf;
   logic overflow_q, overflow_d;

   // Signed overflow: operands agree in sign but the result does not.
   assign alu_ovf = (rd0_data[MSB] == b_xor[MSB]) && (alu_res[MSB] != rd0_data[MSB]);

   always_comb begin
      overflow_d = overflow_q;
      if (flag_upd) begin
         overflow_d = alu_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_exec_datapath_slice.sv
// Directed self-checking bench for exec_datapath_slice (8-bit default width).
module tb_exec_datapath_slice;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] rd0_data, rd1_data, immediate, load_data;
   logic          b_sel, subtract, valid_in;
   logic [1:0]    wr_sel;
   logic [DW-1:0] wr_data;
   logic          wr_valid, carry, zero;
`ifdef EXEC_DATAPATH_OVERFLOW_FLAG_EN
   logic          overflow;
`endif

   int compared   = 0;
   int mismatched = 0;

   exec_datapath_slice #(.DATA_BITS(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd0_data  (rd0_data),
      .rd1_data  (rd1_data),
      .immediate (immediate),
      .load_data (load_data),
      .b_sel     (b_sel),
      .subtract  (subtract),
      .wr_sel    (wr_sel),
      .valid_in  (valid_in),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .carry     (carry),
`ifdef EXEC_DATAPATH_OVERFLOW_FLAG_EN
      .overflow  (overflow),
`endif
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic op(input logic v, input logic [1:0] ws, input logic bs, input logic sb,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                     input logic [7:0] ld);
      valid_in  = v;
      wr_sel    = ws;
      b_sel     = bs;
      subtract  = sb;
      rd0_data  = a;
      rd1_data  = b;
      immediate = imm;
      load_data = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                          input logic c, input logic z);
      chk({tag, ".wr_data"},  32'(wr_data),  32'(d));
      chk({tag, ".wr_valid"}, 32'(wr_valid), 32'(v));
      chk({tag, ".carry"},    32'(carry),    32'(c));
      chk({tag, ".zero"},     32'(zero),     32'(z));
   endtask

   initial begin
      reset = 1'b1;
      op(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      op(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef EXEC_DATAPATH_OVERFLOW_FLAG_EN
      chk("reset.overflow", 32'(overflow), 32'(0));
`endif
      reset = 1'b0;

      op(1'b1, 2'd0, 1'b0, 1'b0, 8'h05, 8'h03, 8'h00, 8'h00);
      chk_out("add", 8'h08, 1'b1, 1'b0, 1'b0);
      op(1'b1, 2'd0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h01, 8'h00);
      chk_out("wrap", 8'h00, 1'b1, 1'b1, 1'b1);

      op(1'b1, 2'd0, 1'b0, 1'b1, 8'h05, 8'h03, 8'h00, 8'h00);
      chk_out("sub_pos", 8'h02, 1'b1, 1'b1, 1'b0);
      op(1'b1, 2'd0, 1'b0, 1'b1, 8'h03, 8'h05, 8'h00, 8'h00);
      chk_out("sub_neg", 8'hFE, 1'b1, 1'b0, 1'b0);
      op(1'b1, 2'd0, 1'b1, 1'b1, 8'h07, 8'h00, 8'h07, 8'h00);
      chk_out("sub_zero", 8'h00, 1'b1, 1'b1, 1'b1);

      // Non-ALU writebacks leave carry=1/zero=1 from the last subtract.
      op(1'b1, 2'd1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h5A, 8'h00);
      chk_out("mux_imm", 8'h5A, 1'b1, 1'b1, 1'b1);
      op(1'b1, 2'd2, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 8'hC3);
      chk_out("mux_load", 8'hC3, 1'b1, 1'b1, 1'b1);
      op(1'b1, 2'd3, 1'b0, 1'b1, 8'h11, 8'h02, 8'h00, 8'h00);
      chk_out("mux_rd0", 8'h11, 1'b1, 1'b1, 1'b1);

      op(1'b0, 2'd0, 1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00);
      chk_out("idle1", 8'h11, 1'b0, 1'b1, 1'b1);
      op(1'b0, 2'd0, 1'b1, 1'b1, 8'h33, 8'h00, 8'h44, 8'h55);
      chk_out("idle2", 8'h11, 1'b0, 1'b1, 1'b1);

      op(1'b1, 2'd0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00);
      chk_out("add_after_idle", 8'h02, 1'b1, 1'b0, 1'b0);
      op(1'b1, 2'd0, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h00, 8'h00);
      chk_out("b2b_carry", 8'h10, 1'b1, 1'b1, 1'b0);

      reset = 1'b1;
      op(1'b1, 2'd0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00);
      chk_out("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      op(1'b1, 2'd0, 1'b0, 1'b0, 8'h10, 8'h20, 8'h00, 8'h00);
      chk_out("post_reset", 8'h30, 1'b1, 1'b0, 1'b0);

`ifdef EXEC_DATAPATH_OVERFLOW_FLAG_EN
      op(1'b1, 2'd0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h00, 8'h00);
      chk("ovf_add.wr_data", 32'(wr_data), 32'(8'h80));
      chk("ovf_add.overflow", 32'(overflow), 32'(1));
      op(1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00);
      chk("ovf_hold.overflow", 32'(overflow), 32'(1));
      op(1'b1, 2'd0, 1'b0, 1'b1, 8'h80, 8'h01, 8'h00, 8'h00);
      chk("ovf_sub.wr_data", 32'(wr_data), 32'(8'h7F));
      chk("ovf_sub.overflow", 32'(overflow), 32'(1));
      op(1'b1, 2'd0, 1'b0, 1'b0, 8'h05, 8'h03, 8'h00, 8'h00);
      chk("ovf_none.overflow", 32'(overflow), 32'(0));
`endif

      valid_in = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
